// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard and its match search.
// Scoreboard entries hold destination addresses up to RA_MAX bits wide.
package hazard_pkg;

  localparam int RA_MAX = 8;
  localparam int FWD_W  = 2;

  localparam logic [1:0] LAT_ALU  = 2'd1;
  localparam logic [1:0] LAT_LOAD = 2'd2;

  // Forward-select value meaning "take the register file"; nonzero values name a stage.
  localparam logic [FWD_W-1:0] FWD_RF = 2'd0;

  typedef struct packed {
    logic              vld;
    logic              we;
    logic [RA_MAX-1:0] dst;
    logic [1:0]        lat;
  } sbEntry_t;

  // Unknown latencies are treated as loads so a hazard is never missed.
  function automatic logic [1:0] normLat(input logic [1:0] lat);
    return (lat == LAT_ALU || lat == LAT_LOAD) ? lat : LAT_LOAD;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-producer search for one source operand across the scoreboard entries.
// Only entries FIRST..DEPTH are candidates; the lowest matching index wins.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int RA_W  = 5,
  parameter int FIRST = 1,
  parameter int IDX_W = $clog2(DEPTH + 1)
) (
  input  sbEntry_t         entries [1:DEPTH],
  input  logic [RA_W-1:0]  opReg,
  input  logic             opUse,
  output logic             hit,
  output logic [IDX_W-1:0] hitIdx,
  output logic [1:0]       hitLat
);

  logic [DEPTH:1] matchVec;

  generate
    for (genvar gi = 1; gi <= DEPTH; gi++) begin : gMatch
      assign matchVec[gi] = (gi >= FIRST) && entries[gi].vld && entries[gi].we && opUse
                            && (opReg != '0) && (entries[gi].dst == RA_MAX'(opReg));
    end
  endgenerate

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    hitLat = LAT_ALU;
    for (int k = DEPTH; k >= 1; k--) begin
      if (matchVec[k]) begin
        hit    = 1'b1;
        hitIdx = IDX_W'(k);
        hitLat = entries[k].lat;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight writers, raises stalls and flushes,
// selects forwarding sources for the E and D operands, and counts stall/flush cycles.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16,
  parameter int RA_W  = $clog2(NREG)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             issue_i,
  input  logic [RA_W-1:0]  rs_i,
  input  logic [RA_W-1:0]  rt_i,
  input  logic             rs_use_i,
  input  logic             rt_use_i,
  input  logic             br_i,
  input  logic [RA_W-1:0]  dst_i,
  input  logic             we_i,
  input  logic [1:0]       lat_i,
  input  logic             redirect_i,
  output logic             stall_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic [1:0]       fwd_ae_o,
  output logic [1:0]       fwd_be_o,
  output logic [1:0]       fwd_ad_o,
  output logic [1:0]       fwd_bd_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH + 1);

  sbEntry_t         entries_reg [1:DEPTH];
  logic [RA_W-1:0]  eRs_reg, eRt_reg;
  logic             eRsUse_reg, eRtUse_reg;
  logic [CNT_W-1:0] stallCnt_reg, flushCnt_reg;

  logic             hitAE, hitBE, hitAD, hitBD;
  logic [IDX_W-1:0] idxAE, idxBE, idxAD, idxBD;
  logic [1:0]       latAE, latBE, latAD, latBD;
  logic             advance;
  sbEntry_t         dPacket;
  logic             unusedLat;

  hazard_match #(.DEPTH(DEPTH), .RA_W(RA_W), .FIRST(2)) uMatchAE (
    .entries(entries_reg), .opReg(eRs_reg), .opUse(eRsUse_reg),
    .hit(hitAE), .hitIdx(idxAE), .hitLat(latAE));
  hazard_match #(.DEPTH(DEPTH), .RA_W(RA_W), .FIRST(2)) uMatchBE (
    .entries(entries_reg), .opReg(eRt_reg), .opUse(eRtUse_reg),
    .hit(hitBE), .hitIdx(idxBE), .hitLat(latBE));
  hazard_match #(.DEPTH(DEPTH), .RA_W(RA_W), .FIRST(1)) uMatchAD (
    .entries(entries_reg), .opReg(rs_i), .opUse(rs_use_i),
    .hit(hitAD), .hitIdx(idxAD), .hitLat(latAD));
  hazard_match #(.DEPTH(DEPTH), .RA_W(RA_W), .FIRST(1)) uMatchBD (
    .entries(entries_reg), .opReg(rt_i), .opUse(rt_use_i),
    .hit(hitBD), .hitIdx(idxBD), .hitLat(latBD));

  // E-stage producer latency only matters to the stall decision made in D.
  assign unusedLat = ^{latAE, latBE};

  // A D consumer needs the value in D (branch) or one stage later (everything else).
  function automatic logic needStall(input logic hit, input logic [IDX_W-1:0] idx,
                                     input logic [1:0] lat, input logic br);
    logic [7:0] k;
    logic [7:0] l;
    k = 8'(idx);
    l = 8'(lat);
    return hit && (br ? (k <= l) : (k + 8'd1 <= l));
  endfunction

  assign stall_o   = issue_i & (needStall(hitAD, idxAD, latAD, br_i) |
                                needStall(hitBD, idxBD, latBD, br_i));
  assign flush_d_o = redirect_i & ~stall_o;
  assign flush_e_o = stall_o | flush_d_o;
  assign advance   = issue_i & ~stall_o;

  assign fwd_ae_o = hitAE ? FWD_W'(idxAE - IDX_W'(1)) : FWD_RF;
  assign fwd_be_o = hitBE ? FWD_W'(idxBE - IDX_W'(1)) : FWD_RF;
  assign fwd_ad_o = (hitAD && (8'(idxAD) > 8'(latAD))) ? FWD_W'(idxAD) : FWD_RF;
  assign fwd_bd_o = (hitBD && (8'(idxBD) > 8'(latBD))) ? FWD_W'(idxBD) : FWD_RF;

  always_comb begin
    dPacket = '0;
    if (advance) begin
      dPacket.vld = 1'b1;
      dPacket.we  = we_i;
      dPacket.dst = RA_MAX'(dst_i);
      dPacket.lat = normLat(lat_i);
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      entries_reg[1] <= '0;
      eRs_reg        <= '0;
      eRt_reg        <= '0;
      eRsUse_reg     <= 1'b0;
      eRtUse_reg     <= 1'b0;
    end else begin
      entries_reg[1] <= dPacket;
      eRs_reg        <= rs_i;
      eRt_reg        <= rt_i;
      eRsUse_reg     <= advance & rs_use_i;
      eRtUse_reg     <= advance & rt_use_i;
    end
  end

  generate
    for (genvar gi = 2; gi <= DEPTH; gi++) begin : gShift
      always_ff @(posedge CLK) begin
        if (reset) entries_reg[gi] <= '0;
        else       entries_reg[gi] <= entries_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (reset) begin
      stallCnt_reg <= '0;
      flushCnt_reg <= '0;
    end else begin
      if (stall_o && (stallCnt_reg != '1))   stallCnt_reg <= stallCnt_reg + 1'b1;
      if (flush_d_o && (flushCnt_reg != '1)) flushCnt_reg <= flushCnt_reg + 1'b1;
    end
  end

  assign stall_cnt_o = stallCnt_reg;
  assign flush_cnt_o = flushCnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenario bench for hazard_scoreboard; counters are narrowed so saturation is reachable.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

  localparam int NREG  = 32;
  localparam int DEPTH = 3;
  localparam int CNT_W = 8;
  localparam int RA_W  = 5;

  logic             CLK = 1'b0;
  logic             reset = 1'b1;
  logic             issue_i, rs_use_i, rt_use_i, br_i, we_i, redirect_i;
  logic [RA_W-1:0]  rs_i, rt_i, dst_i;
  logic [1:0]       lat_i;
  logic             stall_o, flush_d_o, flush_e_o;
  logic [1:0]       fwd_ae_o, fwd_be_o, fwd_ad_o, fwd_bd_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int checks = 0;
  int errs   = 0;

  always #5 CLK = ~CLK;

  hazard_scoreboard #(.NREG(NREG), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset(reset), .issue_i(issue_i), .rs_i(rs_i), .rt_i(rt_i),
    .rs_use_i(rs_use_i), .rt_use_i(rt_use_i), .br_i(br_i), .dst_i(dst_i),
    .we_i(we_i), .lat_i(lat_i), .redirect_i(redirect_i), .stall_o(stall_o),
    .flush_d_o(flush_d_o), .flush_e_o(flush_e_o), .fwd_ae_o(fwd_ae_o),
    .fwd_be_o(fwd_be_o), .fwd_ad_o(fwd_ad_o), .fwd_bd_o(fwd_bd_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o));

  task automatic drive(input logic iss, input int rs, input logic rsu, input int rt,
                       input logic rtu, input logic br, input int dst, input logic we,
                       input int lat, input logic redir);
    issue_i = iss; rs_i = RA_W'(rs); rs_use_i = rsu; rt_i = RA_W'(rt); rt_use_i = rtu;
    br_i = br; dst_i = RA_W'(dst); we_i = we; lat_i = 2'(lat); redirect_i = redir;
    #1;
    $display("txn t=%0t rst=%0b iss=%0b rs=%0d/%0b rt=%0d/%0b br=%0b dst=%0d we=%0b lat=%0d rd=%0b -> st=%0b fd=%0b fe=%0b ae=%0d be=%0d ad=%0d bd=%0d sc=%0d fc=%0d",
             $time, reset, iss, rs, rsu, rt, rtu, br, dst, we, lat, redir, stall_o, flush_d_o,
             flush_e_o, fwd_ae_o, fwd_be_o, fwd_ad_o, fwd_bd_o, stall_cnt_o, flush_cnt_o);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    idle();
    checks++;
    if ({stall_o, flush_d_o, flush_e_o, fwd_ae_o, fwd_be_o, fwd_ad_o, fwd_bd_o} !== 11'd0) begin
      errs++; $display("FAIL reset_outputs: got st=%0b fd=%0b fe=%0b fwd=%0d%0d%0d%0d expected all 0",
                       stall_o, flush_d_o, flush_e_o, fwd_ae_o, fwd_be_o, fwd_ad_o, fwd_bd_o);
    end
    checks++;
    if (stall_cnt_o !== 8'd0 || flush_cnt_o !== 8'd0) begin
      errs++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 2, 1, 2, 0);               // lw r2
    checks++;
    if (stall_o !== 1'b0) begin errs++; $display("FAIL lu_lw_nostall: got %0b expected 0", stall_o); end
    tick();
    drive(1, 2, 1, 4, 1, 0, 3, 1, 1, 0);               // add r3,r2,r4
    checks++;
    if (stall_o !== 1'b1) begin errs++; $display("FAIL lu_stall: got %0b expected 1", stall_o); end
    checks++;
    if (flush_e_o !== 1'b1 || flush_d_o !== 1'b0) begin
      errs++; $display("FAIL lu_flush: got fe=%0b fd=%0b expected fe=1 fd=0", flush_e_o, flush_d_o);
    end
    tick();
    drive(1, 2, 1, 4, 1, 0, 3, 1, 1, 0);
    checks++;
    if (stall_o !== 1'b0) begin errs++; $display("FAIL lu_release: got %0b expected 0", stall_o); end
    tick();
    idle();
    checks++;
    if (fwd_ae_o !== 2'd2 || fwd_be_o !== 2'd0) begin
      errs++; $display("FAIL lu_fwd_e: got ae=%0d be=%0d expected ae=2 be=0", fwd_ae_o, fwd_be_o);
    end
    checks++;
    if (stall_cnt_o !== 8'd1) begin errs++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt_o); end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    drive(1, 1, 1, 2, 1, 0, 5, 1, 1, 0);               // add r5,r1,r2
    tick();
    drive(1, 5, 1, 0, 1, 1, 0, 0, 1, 0);               // beq r5,r0
    checks++;
    if (stall_o !== 1'b1) begin errs++; $display("FAIL br_alu_stall: got %0b expected 1", stall_o); end
    tick();
    drive(1, 5, 1, 0, 1, 1, 0, 0, 1, 0);
    checks++;
    if (stall_o !== 1'b0 || fwd_ad_o !== 2'd2 || fwd_bd_o !== 2'd0) begin
      errs++; $display("FAIL br_alu_fwd: got st=%0b ad=%0d bd=%0d expected st=0 ad=2 bd=0",
                       stall_o, fwd_ad_o, fwd_bd_o);
    end
    tick();
    for (int i = 0; i < 3; i++) begin idle(); tick(); end
    drive(1, 6, 1, 0, 0, 0, 5, 1, 2, 0);               // lw r5
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 5, 1, 0, 1, 1, 0, 0, 1, 0);             // beq r5,r0
      checks++;
      if (stall_o !== 1'b1) begin errs++; $display("FAIL br_load_stall%0d: got %0b expected 1", i, stall_o); end
      tick();
    end
    drive(1, 5, 1, 0, 1, 1, 0, 0, 1, 0);
    checks++;
    if (stall_o !== 1'b0 || fwd_ad_o !== 2'd3) begin
      errs++; $display("FAIL br_load_fwd: got st=%0b ad=%0d expected st=0 ad=3", stall_o, fwd_ad_o);
    end
    checks++;
    if (stall_cnt_o !== 8'd3) begin errs++; $display("FAIL br_stall_cnt: got %0d expected 3", stall_cnt_o); end
    tick();
  endtask

  task automatic test_youngest();
    do_reset();
    drive(1, 7, 1, 8, 1, 0, 1, 1, 1, 0);               // add r1,r7,r8
    tick();
    drive(1, 7, 1, 8, 1, 0, 1, 1, 1, 0);               // add r1,r7,r8
    tick();
    drive(1, 1, 1, 1, 1, 0, 6, 1, 1, 0);               // sub r6,r1,r1
    checks++;
    if (stall_o !== 1'b0) begin errs++; $display("FAIL yw_nostall: got %0b expected 0", stall_o); end
    tick();
    idle();
    checks++;
    if (fwd_ae_o !== 2'd1 || fwd_be_o !== 2'd1) begin
      errs++; $display("FAIL yw_fwd_e: got ae=%0d be=%0d expected 1/1", fwd_ae_o, fwd_be_o);
    end
    tick();
  endtask

  task automatic test_r0();
    do_reset();
    drive(1, 3, 1, 0, 0, 0, 0, 1, 2, 0);               // lw r0
    tick();
    drive(1, 0, 1, 0, 1, 1, 0, 0, 1, 0);               // beq r0,r0
    checks++;
    if (stall_o !== 1'b0 || fwd_ad_o !== 2'd0 || fwd_bd_o !== 2'd0) begin
      errs++; $display("FAIL r0_branch: got st=%0b ad=%0d bd=%0d expected 0/0/0", stall_o, fwd_ad_o, fwd_bd_o);
    end
    tick();
    drive(1, 0, 1, 0, 1, 0, 7, 1, 1, 0);               // add r7,r0,r0
    checks++;
    if (stall_o !== 1'b0) begin errs++; $display("FAIL r0_alu_stall: got %0b expected 0", stall_o); end
    tick();
    idle();
    checks++;
    if (fwd_ae_o !== 2'd0 || fwd_be_o !== 2'd0) begin
      errs++; $display("FAIL r0_fwd_e: got ae=%0d be=%0d expected 0/0", fwd_ae_o, fwd_be_o);
    end
    tick();
  endtask

  task automatic test_illegal_lat();
    for (int v = 0; v < 4; v += 3) begin
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 9, 1, v, 0);             // producer of r9 with lat 0 or 3
      tick();
      drive(1, 9, 1, 0, 0, 0, 10, 1, 1, 0);
      checks++;
      if (stall_o !== 1'b1) begin errs++; $display("FAIL lat%0d_stall: got %0b expected 1", v, stall_o); end
      tick();
      drive(1, 9, 1, 0, 0, 0, 10, 1, 1, 0);
      checks++;
      if (stall_o !== 1'b0) begin errs++; $display("FAIL lat%0d_release: got %0b expected 0", v, stall_o); end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 0, 0, 1, 1);               // taken jump, no hazard
    checks++;
    if (flush_d_o !== 1'b1 || flush_e_o !== 1'b1 || flush_cnt_o !== 8'd0) begin
      errs++; $display("FAIL rd_flush: got fd=%0b fe=%0b fc=%0d expected 1/1/0", flush_d_o, flush_e_o, flush_cnt_o);
    end
    tick();
    idle();
    checks++;
    if (flush_cnt_o !== 8'd1 || flush_d_o !== 1'b0) begin
      errs++; $display("FAIL rd_count: got fc=%0d fd=%0b expected 1/0", flush_cnt_o, flush_d_o);
    end
    tick();
    drive(1, 0, 0, 0, 0, 0, 2, 1, 2, 0);               // lw r2
    tick();
    drive(1, 2, 1, 0, 1, 1, 0, 0, 1, 1);               // beq r2,r0 taken, must stall
    checks++;
    if (stall_o !== 1'b1 || flush_d_o !== 1'b0 || flush_e_o !== 1'b1) begin
      errs++; $display("FAIL rd_in_stall: got st=%0b fd=%0b fe=%0b expected 1/0/1", stall_o, flush_d_o, flush_e_o);
    end
    tick();
    idle();
    checks++;
    if (flush_cnt_o !== 8'd1) begin errs++; $display("FAIL rd_count_hold: got %0d expected 1", flush_cnt_o); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 2, 1, 2, 0);               // lw r2
    tick();
    drive(1, 2, 1, 0, 0, 0, 3, 1, 1, 0);               // add r3,r2
    checks++;
    if (stall_o !== 1'b1) begin errs++; $display("FAIL rms_pre: got %0b expected 1", stall_o); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1, 2, 1, 0, 0, 0, 3, 1, 1, 0);
    checks++;
    if (stall_o !== 1'b0) begin errs++; $display("FAIL rms_stall: got %0b expected 0", stall_o); end
    checks++;
    if (stall_cnt_o !== 8'd0 || flush_cnt_o !== 8'd0) begin
      errs++; $display("FAIL rms_counters: got %0d/%0d expected 0/0", stall_cnt_o, flush_cnt_o);
    end
    tick();
  endtask

  task automatic test_saturation();
    int nstall;
    int cyc;
    logic seen100;
    nstall  = 0;
    cyc     = 0;
    seen100 = 1'b0;
    do_reset();
    while (nstall < (1 << CNT_W) + 5 && cyc < 2000) begin
      drive(1, 2, 1, 0, 0, 1, 2, 1, 2, 0);             // branch-resolved load reading its own dst
      if (stall_o === 1'b1) nstall++;
      tick();
      cyc++;
      if (nstall == 100 && !seen100) begin
        seen100 = 1'b1;
        checks++;
        if (stall_cnt_o !== 8'd100) begin errs++; $display("FAIL sat_mid: got %0d expected 100", stall_cnt_o); end
      end
    end
    checks++;
    if (nstall < (1 << CNT_W) + 5) begin
      errs++; $display("FAIL sat_budget: got %0d stall cycles expected %0d", nstall, (1 << CNT_W) + 5);
    end
    idle();
    checks++;
    if (stall_cnt_o !== 8'hFF) begin errs++; $display("FAIL sat_value: got %0d expected 255", stall_cnt_o); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_youngest();
    test_r0();
    test_illegal_lat();
    test_redirect();
    test_reset_mid_stall();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
